sha256_round_engine: RTL and testbench
======================================

// Module: sha256_round_engine
// PURPOSE
//  Parametrised SHA-256 compression engine: runs all 64 rounds on one 512-bit block, ROUNDS_PER_CYCLE
//  rounds per clock, with a start/busy/done handshake, a w_valid stall from the message scheduler,
//  and the final feed-forward add (H + a..h). Sits between the message-schedule expander and the
//  nonce/midstate controller in the miner datapath.
// PARAMETERS
//  ROUNDS_PER_CYCLE  1   rounds unrolled per clock; legal 1,2,4,8 (elaboration error otherwise)
// PORTS
//  clk        in   1       clock
//  n_rst      in   1       asynchronous active-low reset
//  start      in   1       begin a block; sampled only in IDLE
//  hash_in    in   256     chaining value H0..H7, H0 at [255:224]
//  w_valid    in   1       w_in/k_in valid for current round group
//  w_in       in   32*U    U=ROUNDS_PER_CYCLE; lane j [32j+31:32j] = W[round_idx+j]
//  k_in       in   32*U    same lane mapping, K[round_idx+j]
//  round_idx  out  6       first round index of current group
//  busy       out  1       high in RUN and FINAL
//  done       out  1       one-cycle pulse, hash_out valid
//  hash_out   out  256     H + final a..h, per-word mod 2^32, H0 at [255:224]
// BEHAVIOUR
//  Reset: state IDLE; a..h, saved H, round_idx, hash_out = 0; busy = done = 0.
//  States IDLE -> RUN -> FINAL -> IDLE.
//  IDLE: start=1 -> a..h and saved H <= hash_in, round_idx <= 0, go RUN. start=0: hold.
//  RUN: w_valid=1 -> apply U rounds chained (lane 0 first), round_idx += U;
//   if round_idx was 64-U -> FINAL. w_valid=0 -> hold all state (stall, no limit).
//   Round: T1=h+S1(e)+Ch(e,f,g)+K+W; T2=S0(a)+Maj(a,b,c); S1=ror6^ror11^ror25 of e,
//   S0=ror2^ror13^ror22 of a; all adds mod 2^32; shift h<=g..b<=a, e<=d+T1, a<=T1+T2.
//  FINAL: hash_out[i] <= H[i] + reg[i], done <= 1 (registered, high next cycle), go IDLE.
//  Latency without stalls: start edge + 64/U RUN edges + 1 FINAL edge; done high in
//   cycle after; each w_valid=0 cycle in RUN adds one cycle.
//  start while busy: ignored. start in the done cycle (IDLE): accepted, back-to-back.
//  hash_out holds last digest until next FINAL; a..h not exported.
//  round_idx wraps to 0 on entering FINAL; round_idx always multiple of U.
//  Reset mid-operation: immediate return to reset values, no done pulse.
// CONFIGURATION
//  SHA256_KROM_EN defined: K taken from package constant array indexed by round_idx+j;
//   k_in ignored (port kept for pin compatibility).
//  Not defined: K taken from k_in lanes; no ROM.
// STRUCTURE
//  sha256_pkg: K[0:63] constant array, state enum {IDLE,RUN,FINAL}, functions
//   big_sigma0/1, ch, maj; typedef work_t struct of 8x32-bit words.
//  Sub-module sha256_round: combinational single round (work_t in, W, K -> work_t out);
//   instantiated U times in a generate chain; engine owns all registers and FSM.
// TESTING
//  1 U=1, H=IV, W from padded "abc", w_valid=1 -> done at cycle 66 after start,
//    hash_out=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
//  2 U=4 same vector -> identical digest, done 18 cycles after start; round_idx 0,4,..,60.
//  3 U=1, w_valid low 1 of every 3 RUN cycles -> same digest, done delayed by stall count.
//  4 start pulsed while busy, then n_rst low at round_idx=20 -> no done, outputs all 0,
//    next start runs vector 1 cleanly.
//  5 start in done cycle with second block (two-block "abcdbcdecdef..." vector) ->
//    second done gives 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
//  6 SHA256_KROM_EN defined, k_in=32'hDEADBEEF all lanes -> vector 1 digest unchanged.

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 shared types, round constants and round helper functions.
// Optional K ROM selected in the engine by SHA256_KROM_EN.
package sha256_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FINAL
   } state_t;

   // Working variables, a in the top word so a packed
   // copy lines up with the H0-at-MSB chaining value.
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] d;
      logic [31:0] e;
      logic [31:0] f;
      logic [31:0] g;
      logic [31:0] h;
   } work_t;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return {x[1:0],  x[31:2]}
           ^ {x[12:0], x[31:13]}
           ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return {x[5:0],  x[31:6]}
           ^ {x[10:0], x[31:11]}
           ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [31:0] ch(
      input logic [31:0] x,
      input logic [31:0] y,
      input logic [31:0] z
   );
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(
      input logic [31:0] x,
      input logic [31:0] y,
      input logic [31:0] z
   );
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

endpackage

// File: rtl/sha256_round.sv
// Combinational single SHA-256 round: work_t in, W and K -> work_t out.
// Ports: s_in (a..h before), w, k (round inputs), s_out (a..h after).
module sha256_round
   import sha256_pkg::*;
(
   input  work_t       s_in,
   input  logic [31:0] w,
   input  logic [31:0] k,
   output work_t       s_out
);

   logic [31:0] t1;
   logic [31:0] t2;

   always_comb begin
      t1 = s_in.h
         + big_sigma1(s_in.e)
         + ch(s_in.e, s_in.f, s_in.g)
         + k
         + w;
      t2 = big_sigma0(s_in.a)
         + maj(s_in.a, s_in.b, s_in.c);
      s_out   = s_in;
      s_out.h = s_in.g;
      s_out.g = s_in.f;
      s_out.f = s_in.e;
      s_out.e = s_in.d + t1;
      s_out.d = s_in.c;
      s_out.c = s_in.b;
      s_out.b = s_in.a;
      s_out.a = t1 + t2;
   end

endmodule

// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine, ROUNDS_PER_CYCLE rounds per clock, with feed-forward.
// Ports: clk, n_rst, start, hash_in, w_valid, w_in, k_in -> round_idx, busy, done,
// hash_out. Define SHA256_KROM_EN to take K from the package ROM (k_in ignored).
module sha256_round_engine
   import sha256_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic                          clk,
   input  logic                          n_rst,
   input  logic                          start,
   input  logic [255:0]                  hash_in,
   input  logic                          w_valid,
   input  logic [32*ROUNDS_PER_CYCLE-1:0] w_in,
   input  logic [32*ROUNDS_PER_CYCLE-1:0] k_in,
   output logic [5:0]                    round_idx,
   output logic                          busy,
   output logic                          done,
   output logic [255:0]                  hash_out
);

   localparam int U = ROUNDS_PER_CYCLE;
   localparam logic [5:0] LAST_IDX = 6'(64 - U);
   localparam logic [5:0] STEP     = 6'(U);

   if (!(U == 1 || U == 2 || U == 4 || U == 8)) begin : g_bad_u
      $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
   end

   state_t       state;
   work_t        work;
   logic [255:0] h_save;
   logic [255:0] work_bits;
   logic [255:0] digest;
   logic [31:0]  k_lane [U];
   work_t        chain [U+1];

   assign chain[0]  = work;
   assign work_bits = work;

`ifdef SHA256_KROM_EN
   // k_in stays on the pin list only for drop-in compatibility.
   logic unused_k_in;
   assign unused_k_in = ^k_in;

   for (genvar j = 0; j < U; j++) begin : g_krom
      logic [5:0] kidx;
      assign kidx      = round_idx + 6'(j);
      assign k_lane[j] = K[kidx];
   end
`else
   for (genvar j = 0; j < U; j++) begin : g_kin
      assign k_lane[j] = k_in[32*j +: 32];
   end
`endif

   // Lane 0 is the earliest round of the group.
   for (genvar j = 0; j < U; j++) begin : g_rnd
      sha256_round u_round (
         .s_in  (chain[j]),
         .w     (w_in[32*j +: 32]),
         .k     (k_lane[j]),
         .s_out (chain[j+1])
      );
   end

   always_comb begin
      digest = '0;
      for (int i = 0; i < 8; i++) begin
         digest[32*i +: 32] = h_save[32*i +: 32]
                            + work_bits[32*i +: 32];
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= IDLE;
         work      <= '0;
         h_save    <= '0;
         round_idx <= '0;
         hash_out  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  work      <= hash_in;
                  h_save    <= hash_in;
                  round_idx <= '0;
                  busy      <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               // w_valid low is a scheduler stall: nothing moves.
               if (w_valid) begin
                  work <= chain[U];
                  if (round_idx == LAST_IDX) begin
                     round_idx <= '0;
                     state     <= FINAL;
                  end else begin
                     round_idx <= round_idx + STEP;
                  end
               end
            end
            FINAL: begin
               hash_out <= digest;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_round_engine.sv
// Bench for sha256_round_engine: U=1 and U=4 instances, directed steps,
// digest scoreboard queue; honours SHA256_KROM_EN when driving k_in.
module tb_sha256_round_engine;

   logic clk = 1'b0;
   logic n_rst;
   always #5 clk = ~clk;

   logic         start1, w_valid1, busy1, done1;
   logic [255:0] hash_in1, hash_out1;
   logic [31:0]  w_in1, k_in1;
   logic [5:0]   round_idx1;

   logic         start4, w_valid4, busy4, done4;
   logic [255:0] hash_in4, hash_out4;
   logic [127:0] w_in4, k_in4;
   logic [5:0]   round_idx4;

   sha256_round_engine #(.ROUNDS_PER_CYCLE(1)) dut1 (
      .clk(clk), .n_rst(n_rst), .start(start1), .hash_in(hash_in1),
      .w_valid(w_valid1), .w_in(w_in1), .k_in(k_in1),
      .round_idx(round_idx1), .busy(busy1), .done(done1),
      .hash_out(hash_out1)
   );

   sha256_round_engine #(.ROUNDS_PER_CYCLE(4)) dut4 (
      .clk(clk), .n_rst(n_rst), .start(start4), .hash_in(hash_in4),
      .w_valid(w_valid4), .w_in(w_in4), .k_in(k_in4),
      .round_idx(round_idx4), .busy(busy4), .done(done4),
      .hash_out(hash_out4)
   );

   logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [255:0] IV =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] D_ABC =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] D_2BLK =
      256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [511:0] B_ABC = {32'h61626380, {14{32'h0}}, 32'h18};
   localparam logic [511:0] B_M1 = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
   };
   localparam logic [511:0] B_M2 = {{15{32'h0}}, 32'h1c0};

   logic [31:0]  wm [2][64];
   logic [255:0] exp_q [$];
   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] kval(input int i);
`ifdef SHA256_KROM_EN
      return (i >= 0) ? 32'hDEADBEEF : 32'h0;
`else
      return KT[i];
`endif
   endfunction

   // Message scheduler stand-in: serves the round group the DUT asks for.
   always_comb begin
      w_in1 = wm[0][round_idx1];
      k_in1 = kval(int'(round_idx1));
      w_in4 = '0;
      k_in4 = '0;
      for (int j = 0; j < 4; j++) begin
         w_in4[32*j +: 32] = wm[1][(int'(round_idx4) + j) % 64];
         k_in4[32*j +: 32] = kval((int'(round_idx4) + j) % 64);
      end
   end

   task automatic load_w(input int d, input logic [511:0] blk);
      logic [31:0] s0, s1;
      for (int i = 0; i < 16; i++) wm[d][i] = blk[511-32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         s0 = ror(wm[d][i-15], 7) ^ ror(wm[d][i-15], 18) ^ (wm[d][i-15] >> 3);
         s1 = ror(wm[d][i-2], 17) ^ ror(wm[d][i-2], 19) ^ (wm[d][i-2] >> 10);
         wm[d][i] = s1 + wm[d][i-7] + s0 + wm[d][i-16];
      end
   endtask

   function automatic logic [255:0] compress(input logic [255:0] h, input int d);
      logic [31:0] v [8];
      logic [31:0] t1, t2;
      logic [255:0] r;
      for (int i = 0; i < 8; i++) v[i] = h[255-32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + wm[d][t];
         t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) r[255-32*i -: 32] = h[255-32*i -: 32] + v[i];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [5:0] ridx(input int d);
      return (d == 0) ? round_idx1 : round_idx4;
   endfunction
   function automatic logic get_busy(input int d);
      return (d == 0) ? busy1 : busy4;
   endfunction
   function automatic logic get_done(input int d);
      return (d == 0) ? done1 : done4;
   endfunction
   function automatic logic [255:0] get_hash(input int d);
      return (d == 0) ? hash_out1 : hash_out4;
   endfunction

   task automatic drive(input int d, input logic st, input logic [255:0] h,
                        input logic wv);
      if (d == 0) begin
         start1 = st; hash_in1 = h; w_valid1 = wv;
      end else begin
         start4 = st; hash_in4 = h; w_valid4 = wv;
      end
   endtask

   // Runs one block from IDLE; stall_mod>0 drops w_valid every stall_mod-th
   // RUN cycle, pulse_at>=0 pulses start (with a bogus hash_in) while busy.
   task automatic run(input int d, input logic [255:0] h,
                      input logic [511:0] blk, input int stall_mod,
                      input int pulse_at, input logic [255:0] expv);
      int  u = (d == 0) ? 1 : 4;
      int  r = 0;
      int  n = 0;
      int  k = 0;
      int  stalls = 0;
      logic stall;
      load_w(d, blk);
      exp_q.push_back(expv);
      drive(d, 1'b1, h, 1'b0);
      @(posedge clk); #1; n++;
      drive(d, 1'b0, h, 1'b0);
      chk("busy_on_start", 256'(get_busy(d)), 256'(1));
      chk("done_is_pulse", 256'(get_done(d)), 256'(0));
      while (r < 64) begin
         chk("round_idx", 256'(ridx(d)), 256'(r));
         stall = (stall_mod > 0) && ((k % stall_mod) == stall_mod - 1);
         k++;
         drive(d, (r == pulse_at), (r == pulse_at) ? ~h : h, !stall);
         @(posedge clk); #1; n++;
         drive(d, 1'b0, h, 1'b0);
         if (stall) stalls++;
         else r += u;
      end
      chk("round_idx_wrap", 256'(ridx(d)), 256'(0));
      chk("busy_final", 256'(get_busy(d)), 256'(1));
      @(posedge clk); #1; n++;
      chk("done", 256'(get_done(d)), 256'(1));
      chk("busy_clear", 256'(get_busy(d)), 256'(0));
      chk("latency", 256'(n), 256'(2 + 64 / u + stalls));
      chk("digest", get_hash(d), exp_q.pop_front());
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [255:0] mid;
      n_rst = 1'b0;
      drive(0, 1'b0, '0, 1'b0);
      drive(1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 64; i++) begin
         wm[0][i] = '0;
         wm[1][i] = '0;
      end
      #12;
      for (int d = 0; d < 2; d++) begin
         chk("rst_round_idx", 256'(ridx(d)), 256'(0));
         chk("rst_busy", 256'(get_busy(d)), 256'(0));
         chk("rst_done", 256'(get_done(d)), 256'(0));
         chk("rst_hash", get_hash(d), 256'(0));
      end
      @(posedge clk); #1;
      n_rst = 1'b1;
      @(posedge clk); #1;

      // U=1 "abc", with start pulsed mid-run.
      run(0, IV, B_ABC, 0, 10, D_ABC);
      // Back-to-back start in the done cycle, with stalls.
      run(0, IV, B_ABC, 3, -1, D_ABC);
      chk("hold_hash", hash_out1, D_ABC);
      // Two-block message, both blocks chained back-to-back.
      load_w(0, B_M1);
      mid = compress(IV, 0);
      run(0, IV, B_M1, 0, -1, mid);
      run(0, mid, B_M2, 5, -1, D_2BLK);

      // U=4 instance.
      run(1, IV, B_ABC, 0, -1, D_ABC);
      load_w(1, B_M1);
      mid = compress(IV, 1);
      run(1, IV, B_M1, 0, -1, mid);
      run(1, mid, B_M2, 2, 20, D_2BLK);

      // Reset mid-operation on the U=1 instance.
      load_w(0, B_ABC);
      drive(0, 1'b1, IV, 1'b1);
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
         drive(0, (i == 5), (i == 5) ? ~IV : IV, 1'b1);
         @(posedge clk); #1;
      end
      drive(0, 1'b0, IV, 1'b0);
      chk("abort_at_20", 256'(round_idx1), 256'(20));
      n_rst = 1'b0;
      #1;
      chk("abort_round_idx", 256'(round_idx1), 256'(0));
      chk("abort_busy", 256'(busy1), 256'(0));
      chk("abort_hash", hash_out1, 256'(0));
      chk("abort_hash4", hash_out4, 256'(0));
      @(posedge clk); #1;
      chk("abort_no_done", 256'(done1), 256'(0));
      n_rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_idle_done", 256'(done1), 256'(0));
      run(0, IV, B_ABC, 0, -1, D_ABC);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
